// File: rtl/or_reduce_stream.sv
// rtl/or_reduce_stream.sv - pipelined multi-beat OR/AND/XOR frame reducer with valid/ready output
module or_reduce_stream #(
    parameter int BIT          = 29,
    parameter int NUMBER_INPUT = 16,
    parameter int GROUP        = 4,
    parameter int CNT_W        = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [1:0]                  op,
    input  logic [NUMBER_INPUT*BIT-1:0] IN,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BIT-1:0]              out,
    output logic [CNT_W-1:0]            out_beats
);

    localparam int NG = (NUMBER_INPUT + GROUP - 1) / GROUP;
    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    function automatic logic [BIT-1:0] ident(input logic [1:0] o);
        return (o == OP_AND) ? {BIT{1'b1}} : {BIT{1'b0}};
    endfunction

    function automatic logic [BIT-1:0] red2(input logic [BIT-1:0] a, input logic [BIT-1:0] b,
                                            input logic [1:0] o);
        case (o)
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            default: return a | b;
        endcase
    endfunction

    logic             adv;
    logic             accept;
    logic [1:0]       op_n;
    logic [1:0]       beat_op;
    logic             in_first;
    logic [1:0]       frame_op;
    logic [BIT-1:0]   pad_val;
    logic [BIT-1:0]   words [NG*GROUP];
    logic [BIT-1:0]   part [NG];

    logic             s1_valid;
    logic             s1_last;
    logic [1:0]       s1_op;
    logic [BIT-1:0]   s1_part [NG];

    logic             s2_first;
    logic [BIT-1:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic [BIT-1:0]   beat_red;
    logic [BIT-1:0]   new_acc;
    logic [CNT_W-1:0] new_cnt;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign op_n     = (op == 2'b11) ? OP_OR : op;
    // The first beat of a frame supplies the op; later beats reuse the captured one.
    assign beat_op  = in_first ? op_n : frame_op;
    assign pad_val  = ident(beat_op);

    // Word slots beyond NUMBER_INPUT are filled with the op identity so a short group is harmless.
    for (genvar i = 0; i < NG*GROUP; i++) begin : g_pad
        if (i < NUMBER_INPUT) begin : g_word
            assign words[i] = IN[BIT*i +: BIT];
        end else begin : g_fill
            assign words[i] = pad_val;
        end
    end

    // Stage-1 group partials for the beat on the input.
    always_comb begin
        for (int g = 0; g < NG; g++) begin
            part[g] = ident(beat_op);
            for (int k = 0; k < GROUP; k++) begin
                part[g] = red2(part[g], words[g*GROUP + k], beat_op);
            end
        end
    end

    // Stage-1 register: captures partials and frame op tracking, holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_op    <= OP_OR;
            in_first <= 1'b1;
            frame_op <= OP_OR;
            for (int g = 0; g < NG; g++) begin
                s1_part[g] <= '0;
            end
        end else if (adv) begin
            s1_valid <= in_valid;
            if (accept) begin
                s1_last  <= in_last;
                s1_op    <= beat_op;
                s1_part  <= part;
                in_first <= in_last;
                if (in_first) begin
                    frame_op <= op_n;
                end
            end
        end
    end

    // Stage-2 combine: fold the group partials, then fold into the frame accumulator.
    always_comb begin
        beat_red = ident(s1_op);
        for (int g = 0; g < NG; g++) begin
            beat_red = red2(beat_red, s1_part[g], s1_op);
        end
        new_acc = red2(s2_first ? ident(s1_op) : acc, beat_red, s1_op);
        new_cnt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    end

    // Stage-2 register: accumulate across beats and publish the frame result on its last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            s2_first  <= 1'b1;
            out       <= '0;
            out_beats <= '0;
            out_valid <= 1'b0;
        end else begin
            if (adv && s1_valid) begin
                if (s1_last) begin
                    out       <= new_acc;
                    out_beats <= new_cnt;
                    acc       <= '0;
                    cnt       <= '0;
                    s2_first  <= 1'b1;
                end else begin
                    acc       <= new_acc;
                    cnt       <= new_cnt;
                    s2_first  <= 1'b0;
                end
            end
            if (adv && s1_valid && s1_last) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_or_reduce_stream.sv
// tb/tb_or_reduce_stream.sv - directed self-checking bench for or_reduce_stream
module tb_or_reduce_stream;

    localparam int BIT = 29;
    localparam int N   = 16;
    localparam int CW  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_last;
    logic [1:0]       op;
    logic [N*BIT-1:0] in_data;
    logic             out_ready;
    logic             in_ready,  in_ready3;
    logic             out_valid, out_valid3;
    logic [BIT-1:0]   out,       out3;
    logic [CW-1:0]    out_beats, out_beats3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    or_reduce_stream #(.BIT(BIT), .NUMBER_INPUT(N), .GROUP(4), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .op(op), .IN(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_beats(out_beats)
    );

    or_reduce_stream #(.BIT(BIT), .NUMBER_INPUT(N), .GROUP(3), .CNT_W(CW)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3), .in_last(in_last),
        .op(op), .IN(in_data), .out_valid(out_valid3), .out_ready(out_ready),
        .out(out3), .out_beats(out_beats3)
    );

    task automatic beat(input logic [1:0] o, input logic l, input logic [N*BIT-1:0] d);
        op       = o;
        in_last  = l;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    function automatic logic [N*BIT-1:0] fill(input logic [BIT-1:0] w);
        logic [N*BIT-1:0] v;
        for (int i = 0; i < N; i++) v[BIT*i +: BIT] = w;
        return v;
    endfunction

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; op = 2'b00; in_data = '0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if (out !== '0) begin fails++; $display("FAIL reset_out got %h exp 0", out); end
        tests++; if (out_beats !== '0) begin fails++; $display("FAIL reset_beats got %0d exp 0", out_beats); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_or_single;
        logic [N*BIT-1:0] d;
        for (int i = 0; i < N; i++) d[BIT*i +: BIT] = BIT'(1) << i;
        beat(2'b00, 1'b1, d);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t1_early_valid got %b exp 0", out_valid); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL t1_latency got %b exp 1", out_valid); end
        tests++; if (out !== 29'h0000FFFF) begin fails++; $display("FAIL t1_out got %h exp 0000ffff", out); end
        tests++; if (out_beats !== 8'd1) begin fails++; $display("FAIL t1_beats got %0d exp 1", out_beats); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t1_consumed got %b exp 0", out_valid); end
    endtask

    task automatic test_and_frame;
        logic [N*BIT-1:0] d;
        d = fill(29'h1FFFFFFF);
        beat(2'b01, 1'b0, d);
        beat(2'b01, 1'b0, d);
        d[BIT*5 +: BIT] = 29'h0F0F0F0F;
        beat(2'b01, 1'b1, d);
        @(negedge clk);
        tests++; if (out !== 29'h0F0F0F0F) begin fails++; $display("FAIL t2_out got %h exp 0f0f0f0f", out); end
        tests++; if (out_beats !== 8'd3) begin fails++; $display("FAIL t2_beats got %0d exp 3", out_beats); end
        @(negedge clk);
    endtask

    task automatic test_xor_parity;
        logic [N*BIT-1:0] d;
        d = fill(29'h1);
        beat(2'b10, 1'b0, d);
        beat(2'b10, 1'b1, d);
        d = '0; d[BIT-1:0] = 29'h3;
        beat(2'b10, 1'b1, d);
        tests++; if (out !== 29'h0 || out_beats !== 8'd2 || out_valid !== 1'b1) begin
            fails++; $display("FAIL t3_even got %h/%0d exp 0/2", out, out_beats); end
        @(negedge clk);
        tests++; if (out !== 29'h3 || out_beats !== 8'd1) begin
            fails++; $display("FAIL t3_single got %h/%0d exp 3/1", out, out_beats); end
        @(negedge clk);
    endtask

    task automatic test_op_capture;
        logic [N*BIT-1:0] d;
        d = '0; d[BIT-1:0] = 29'h1;
        beat(2'b00, 1'b0, d);
        d[BIT-1:0] = 29'h2;
        beat(2'b01, 1'b1, d);
        @(negedge clk);
        tests++; if (out !== 29'h3) begin fails++; $display("FAIL op_capture got %h exp 3", out); end
        d = '0; d[BIT-1:0] = 29'h10; d[BIT +: BIT] = 29'h20;
        beat(2'b11, 1'b1, d);
        @(negedge clk);
        tests++; if (out !== 29'h30) begin fails++; $display("FAIL op11_as_or got %h exp 30", out); end
        @(negedge clk);
    endtask

    task automatic test_saturate;
        logic [N*BIT-1:0] d;
        d = '0; d[BIT-1:0] = 29'h1;
        for (int k = 0; k < 259; k++) beat(2'b00, 1'b0, d);
        d[BIT-1:0] = 29'h100;
        beat(2'b00, 1'b1, d);
        @(negedge clk);
        tests++; if (out_beats !== 8'd255) begin fails++; $display("FAIL sat_beats got %0d exp 255", out_beats); end
        tests++; if (out !== 29'h101) begin fails++; $display("FAIL sat_out got %h exp 101", out); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back_backpressure;
        logic [BIT-1:0] vals [3];
        logic [BIT-1:0] got [$];
        int idx;
        vals[0] = 29'hA; vals[1] = 29'hB; vals[2] = 29'hC;
        idx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 7);
            if (idx < 3) begin
                in_valid = 1'b1; in_last = 1'b1; op = 2'b00;
                in_data = '0; in_data[BIT-1:0] = vals[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) got.push_back(out);
            if (cyc >= 2 && cyc <= 6) begin
                tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL t4_stall_ready c%0d got %b exp 0", cyc, in_ready); end
                tests++; if (out !== 29'hA || out_valid !== 1'b1) begin
                    fails++; $display("FAIL t4_stable c%0d got %h/%b exp a/1", cyc, out, out_valid); end
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        tests++; if (got.size() != 3) begin fails++; $display("FAIL t4_count got %0d exp 3", got.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                tests++; if (got[i] !== vals[i]) begin fails++; $display("FAIL t4_order[%0d] got %h exp %h", i, got[i], vals[i]); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        logic [N*BIT-1:0] d;
        d = '0; d[BIT-1:0] = 29'hF0;
        beat(2'b00, 1'b0, d);
        beat(2'b00, 1'b0, d);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL t5_no_valid k%0d got %b exp 0", k, out_valid); end
            @(negedge clk);
        end
        d[BIT-1:0] = 29'h5;
        beat(2'b00, 1'b1, d);
        @(negedge clk);
        tests++; if (out !== 29'h5 || out_beats !== 8'd1 || out_valid !== 1'b1) begin
            fails++; $display("FAIL t5_after got %h/%0d/%b exp 5/1/1", out, out_beats, out_valid); end
        @(negedge clk);
    endtask

    task automatic test_group3_pad;
        beat(2'b01, 1'b1, fill(29'h1FFFFFFF));
        @(negedge clk);
        tests++; if (out3 !== 29'h1FFFFFFF || out_valid3 !== 1'b1) begin
            fails++; $display("FAIL t6_g3_and got %h/%b exp 1fffffff/1", out3, out_valid3); end
        tests++; if (out_beats3 !== 8'd1) begin fails++; $display("FAIL t6_g3_beats got %0d exp 1", out_beats3); end
        tests++; if (out !== 29'h1FFFFFFF) begin fails++; $display("FAIL t6_g4_and got %h exp 1fffffff", out); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_or_single;
        test_and_frame;
        test_xor_parity;
        test_op_capture;
        test_saturate;
        test_back_to_back_backpressure;
        test_mid_reset;
        test_group3_pad;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
